bram_bank_router: RTL and testbench
===================================

# bram_bank_router

Parametrised, pipelined address router between the NTT address generator and the banked coefficient BRAMs. Takes one flat coefficient address per butterfly lane, derives the port-B partner address (`addr + olen`), and splits both into bank index and in-bank offset. It then routes each address onto the matching bank's port A/B with enables, and delays the bank→lane selects so the read-data return crossbar lines up with BRAM latency. Optionally, it detects and counts bank conflicts.

## Interface
Parameters:
- `NUM_BU`, 8, lane count = bank count; power of two, ≥2.
- `ADDR_WIDTH`, 8, flat coefficient address width.
- `RD_LAT`, 1, BRAM read latency in cycles (≥1), used to delay return selects.
- Derived: `LANE_W = $clog2(NUM_BU)`, `BANK_AW = ADDR_WIDTH - LANE_W`.

Ports:
- `clk_i` in 1: clock; one clock domain.
- `rst_i` in 1: reset, synchronous, active-high.
- `valid_i` in 1: lane addresses valid this cycle.
- `addr_i` in `NUM_BU*ADDR_WIDTH`: packed lane addresses; lane k at `[k*ADDR_WIDTH +: ADDR_WIDTH]`.
- `olen_i` in `ADDR_WIDTH`: butterfly distance; sampled with `valid_i`.
- `done_i` in 1: generator finished; pulse.
- `addr_a_o` out `NUM_BU*BANK_AW`: per-bank port-A offset.
- `addr_b_o` out `NUM_BU*BANK_AW`: per-bank port-B offset.
- `en_a_o`, `en_b_o` out `NUM_BU`: per-bank port enables.
- `valid_o` out 1: outputs valid.
- `sel_a_o`, `sel_b_o` out `NUM_BU*LANE_W`: per-bank source lane, `RD_LAT` cycles after `valid_o`.
- `sel_valid_o` out 1: selects valid.
- `done_o` out 1: `done_i` aligned to `valid_o` timing.
- `conflict_o` out 1: bank conflict in current output beat.
- `conflict_cnt_o` out 16: saturating conflict-beat counter.

## Operation
- Decode per lane k:
  - A address = `addr_i[k]`.
  - B address = `(addr_i[k] + olen_i) mod 2^ADDR_WIDTH`; the carry is dropped, so wrap-around is intended.
  - Bank = top `LANE_W` bits; offset = low `BANK_AW` bits.
- Route A and B independently. For bank b, the lowest-numbered lane whose bank equals b wins:
  - `addr_*_o[b]` = winner's offset.
  - `en_*_o[b]` = 1.
  - `sel_*_o[b]` = winner's lane index.
- A bank with no requesting lane gets offset 0, enable 0, select 0.
- Enables are 0 whenever `valid_o` = 0.
- A conflict exists when two or more lanes target the same bank on the same port (A or B) in one beat. Losing lanes are dropped; no retry.
- No backpressure: every valid beat is accepted and emitted.
- Arithmetic is unsigned. `olen_i` is the same width as the address.

## Timing
- Stage 1: register lane addresses, `olen`, valid, done; compute B addresses.
- Stage 2: register bank-decoded, crossbar-routed outputs and conflict flag.
- Latency `valid_i` → `valid_o` = 2 cycles; throughput one beat per cycle; back-to-back beats supported.
- `done_o` = `done_i` delayed 2 cycles.
- `sel_*_o` / `sel_valid_o` = stage-2 selects/valid delayed a further `RD_LAT` cycles through a shift register.
- Reset (any cycle, including mid-stream):
  - All outputs 0 the cycle after `rst_i` is sampled high: addresses, enables, selects, valids, `done_o`, `conflict_o`, `conflict_cnt_o`.
  - All pipeline and select-delay stages are flushed; no pre-reset beat emerges afterwards.
- `conflict_cnt_o`:
  - Increments by 1 in the cycle `conflict_o` is registered high.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- A beat with `valid_i` = 0 produces all-zero enables and no conflict, even if `addr_i` collides.

## Configuration
- Macro `BRAM_ROUTE_CONFLICT_CHK_EN`.
- Defined: conflict comparison logic, `conflict_o` and `conflict_cnt_o` are implemented as above.
- Undefined: the comparison and counter logic are not built, and both ports are tied to 0. Routing (lowest lane wins) is unchanged.

## Test plan
All scenarios use `NUM_BU`=8, `ADDR_WIDTH`=8, `RD_LAT`=1.
- No-conflict beat:
  - Stimulus: lane k addr = `k*32`, olen=16, valid pulse.
  - Response: 2 cycles later, every bank has A offset 0, B offset 16, all enables 1, `sel_a[b]=b`; `sel_valid_o` one cycle after that; `conflict_o`=0.
- Wrap-around:
  - Stimulus: lane 7 addr 0xF8, olen 0x10.
  - Response: B = 0x08, so bank 0 gets B offset 8 with `sel_b[0]`=7; bank 7 gets A offset 0x18.
- Conflict:
  - Stimulus: lanes 0 and 3 both addr 0x05, others distinct banks.
  - Response: bank 0 A offset 5 with `sel_a[0]`=0; `conflict_o`=1; `conflict_cnt_o`=1. With the macro undefined: same routing, `conflict_o`=0.
- Streaming plus done:
  - Stimulus: 64 back-to-back beats, then `done_i` pulse.
  - Response: 64 contiguous `valid_o` cycles; `done_o` exactly 2 cycles after `done_i`.
- Reset mid-stream:
  - Stimulus: assert `rst_i` for 1 cycle during beat 10.
  - Response: next cycle all outputs 0; no stale `valid_o` or `sel_valid_o` pulses; `conflict_cnt_o`=0.
- Counter saturation:
  - Stimulus: force 65540 conflicting beats.
  - Response: `conflict_cnt_o` holds 0xFFFF.

Source files
------------

// File: rtl/bram_bank_router.sv
// -----------------------------------------------------------------------------
// bram_bank_router
//
// Pipelined address router between the NTT address generator and the banked
// coefficient BRAMs. Each lane supplies a flat coefficient address. The router
// forms the butterfly partner address (addr + olen, wrapping modulo
// 2^ADDR_WIDTH) and splits both addresses into a bank index (top LANE_W bits)
// and an in-bank offset (low BANK_AW bits). For every bank, the lowest-numbered
// lane that targets it is routed onto that bank's port A (direct address) or
// port B (partner address). Losing lanes are dropped.
//
// Handshake: valid_i has no ready. Every cycle with valid_i high is one beat,
// accepted unconditionally and emitted 2 cycles later on valid_o. The return
// selects (sel_*_o, sel_valid_o) follow valid_o by a further RD_LAT cycles so
// they line up with BRAM read data.
//
// Optional feature: define BRAM_ROUTE_CONFLICT_CHK_EN to build conflict
// detection (conflict_o) and the saturating conflict-beat counter
// (conflict_cnt_o). Without it both ports are tied to 0; routing is the same.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   valid_i            lane addresses valid this cycle
//   addr_i             packed lane addresses, lane k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   olen_i             butterfly distance, sampled with valid_i
//   done_i             generator finished pulse
//   addr_a_o/addr_b_o  per-bank port A/B offsets
//   en_a_o/en_b_o      per-bank port A/B enables
//   valid_o            routed outputs valid
//   sel_a_o/sel_b_o    per-bank source lane, RD_LAT cycles after valid_o
//   sel_valid_o        selects valid
//   done_o             done_i delayed to valid_o timing
//   conflict_o         bank conflict in the current output beat
//   conflict_cnt_o     saturating count of conflict beats
// -----------------------------------------------------------------------------
module bram_bank_router #(
   parameter int NUM_BU     = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int RD_LAT     = 1
) (
   input  logic                                          clk_i,
   input  logic                                          rst_i,
   input  logic                                          valid_i,
   input  logic [NUM_BU*ADDR_WIDTH-1:0]                  addr_i,
   input  logic [ADDR_WIDTH-1:0]                         olen_i,
   input  logic                                          done_i,
   output logic [NUM_BU*(ADDR_WIDTH-$clog2(NUM_BU))-1:0] addr_a_o,
   output logic [NUM_BU*(ADDR_WIDTH-$clog2(NUM_BU))-1:0] addr_b_o,
   output logic [NUM_BU-1:0]                             en_a_o,
   output logic [NUM_BU-1:0]                             en_b_o,
   output logic                                          valid_o,
   output logic [NUM_BU*$clog2(NUM_BU)-1:0]              sel_a_o,
   output logic [NUM_BU*$clog2(NUM_BU)-1:0]              sel_b_o,
   output logic                                          sel_valid_o,
   output logic                                          done_o,
   output logic                                          conflict_o,
   output logic [15:0]                                   conflict_cnt_o
);

   localparam int LANE_W  = $clog2(NUM_BU);
   localparam int BANK_AW = ADDR_WIDTH - LANE_W;

   // Stage 1: captured lane addresses and their partner addresses
   logic                  r_s1_valid;
   logic                  r_s1_done;
   logic [ADDR_WIDTH-1:0] r_s1_addr_a [NUM_BU];
   logic [ADDR_WIDTH-1:0] r_s1_addr_b [NUM_BU];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_s1_valid <= 1'b0;
         r_s1_done  <= 1'b0;
         for (int k = 0; k < NUM_BU; k++) begin
            r_s1_addr_a[k] <= '0;
            r_s1_addr_b[k] <= '0;
         end
      end else begin
         r_s1_valid <= valid_i;
         r_s1_done  <= done_i;
         for (int k = 0; k < NUM_BU; k++) begin
            r_s1_addr_a[k] <= addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            // Carry out is dropped on purpose: partner addresses wrap.
            r_s1_addr_b[k] <= addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] + olen_i;
         end
      end
   end

   // Crossbar: lanes are visited in ascending order and a bank is claimed by
   // the first lane that hits it, so the lowest lane wins.
   logic [NUM_BU*BANK_AW-1:0] w_addr_a;
   logic [NUM_BU*BANK_AW-1:0] w_addr_b;
   logic [NUM_BU-1:0]         w_en_a;
   logic [NUM_BU-1:0]         w_en_b;
   logic [NUM_BU*LANE_W-1:0]  w_sel_a;
   logic [NUM_BU*LANE_W-1:0]  w_sel_b;
   logic [LANE_W-1:0]         w_bank_a;
   logic [LANE_W-1:0]         w_bank_b;
`ifdef BRAM_ROUTE_CONFLICT_CHK_EN
   logic                      w_conflict;
`endif

   always_comb begin
      w_addr_a = '0;
      w_addr_b = '0;
      w_en_a   = '0;
      w_en_b   = '0;
      w_sel_a  = '0;
      w_sel_b  = '0;
      w_bank_a = '0;
      w_bank_b = '0;
`ifdef BRAM_ROUTE_CONFLICT_CHK_EN
      w_conflict = 1'b0;
`endif
      if (r_s1_valid) begin
         for (int k = 0; k < NUM_BU; k++) begin
            w_bank_a = r_s1_addr_a[k][ADDR_WIDTH-1 -: LANE_W];
            w_bank_b = r_s1_addr_b[k][ADDR_WIDTH-1 -: LANE_W];
`ifdef BRAM_ROUTE_CONFLICT_CHK_EN
            // A bank already claimed by a lower lane means this lane collides.
            w_conflict = w_conflict | w_en_a[w_bank_a] | w_en_b[w_bank_b];
`endif
            if (!w_en_a[w_bank_a]) begin
               w_en_a[w_bank_a]                       = 1'b1;
               w_addr_a[w_bank_a*BANK_AW +: BANK_AW] = r_s1_addr_a[k][BANK_AW-1:0];
               w_sel_a[w_bank_a*LANE_W +: LANE_W]    = LANE_W'(k);
            end
            if (!w_en_b[w_bank_b]) begin
               w_en_b[w_bank_b]                       = 1'b1;
               w_addr_b[w_bank_b*BANK_AW +: BANK_AW] = r_s1_addr_b[k][BANK_AW-1:0];
               w_sel_b[w_bank_b*LANE_W +: LANE_W]    = LANE_W'(k);
            end
         end
      end
   end

   // Stage 2: routed outputs
   logic                      r_valid;
   logic                      r_done;
   logic [NUM_BU*BANK_AW-1:0] r_addr_a;
   logic [NUM_BU*BANK_AW-1:0] r_addr_b;
   logic [NUM_BU-1:0]         r_en_a;
   logic [NUM_BU-1:0]         r_en_b;
   logic [NUM_BU*LANE_W-1:0]  r_sel_a;
   logic [NUM_BU*LANE_W-1:0]  r_sel_b;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid  <= 1'b0;
         r_done   <= 1'b0;
         r_addr_a <= '0;
         r_addr_b <= '0;
         r_en_a   <= '0;
         r_en_b   <= '0;
         r_sel_a  <= '0;
         r_sel_b  <= '0;
      end else begin
         r_valid  <= r_s1_valid;
         r_done   <= r_s1_done;
         r_addr_a <= w_addr_a;
         r_addr_b <= w_addr_b;
         r_en_a   <= w_en_a;
         r_en_b   <= w_en_b;
         r_sel_a  <= w_sel_a;
         r_sel_b  <= w_sel_b;
      end
   end

   // Return-select delay line, RD_LAT deep; index 0 is the youngest entry.
   logic [NUM_BU*LANE_W-1:0] r_sel_a_d [RD_LAT];
   logic [NUM_BU*LANE_W-1:0] r_sel_b_d [RD_LAT];
   logic [RD_LAT-1:0]        r_sel_vld_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sel_vld_d <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            r_sel_a_d[i] <= '0;
            r_sel_b_d[i] <= '0;
         end
      end else begin
         r_sel_a_d[0]   <= r_sel_a;
         r_sel_b_d[0]   <= r_sel_b;
         r_sel_vld_d[0] <= r_valid;
         for (int i = 1; i < RD_LAT; i++) begin
            r_sel_a_d[i]   <= r_sel_a_d[i-1];
            r_sel_b_d[i]   <= r_sel_b_d[i-1];
            r_sel_vld_d[i] <= r_sel_vld_d[i-1];
         end
      end
   end

`ifdef BRAM_ROUTE_CONFLICT_CHK_EN
   logic        r_conflict;
   logic [15:0] r_conflict_cnt;

   // The counter steps in the same edge that registers conflict_o, so the
   // count already includes the beat being flagged.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_conflict     <= 1'b0;
         r_conflict_cnt <= '0;
      end else begin
         r_conflict <= w_conflict;
         if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
         end
      end
   end

   assign conflict_o     = r_conflict;
   assign conflict_cnt_o = r_conflict_cnt;
`else
   assign conflict_o     = 1'b0;
   assign conflict_cnt_o = 16'h0000;
`endif

   assign addr_a_o    = r_addr_a;
   assign addr_b_o    = r_addr_b;
   assign en_a_o      = r_en_a;
   assign en_b_o      = r_en_b;
   assign valid_o     = r_valid;
   assign done_o      = r_done;
   assign sel_a_o     = r_sel_a_d[RD_LAT-1];
   assign sel_b_o     = r_sel_b_d[RD_LAT-1];
   assign sel_valid_o = r_sel_vld_d[RD_LAT-1];

endmodule

// File: tb/tb_bram_bank_router.sv
// -----------------------------------------------------------------------------
// tb_bram_bank_router
//
// Bench for bram_bank_router with NUM_BU=8, ADDR_WIDTH=8, RD_LAT=1.
// The reference model takes one sampled input beat and derives, bank by bank,
// which lanes target it (bank = addr / 32, offset = addr % 32, partner address
// = (addr + olen) % 256); the first such lane wins, and two or more lanes on
// one port mark a conflict. Expected outputs are those results placed at the
// router's latency, forced to zero around reset.
// -----------------------------------------------------------------------------
module tb_bram_bank_router;

   localparam int NUM_BU  = 8;
   localparam int AW      = 8;
   localparam int RD_LAT  = 1;
   localparam int LANE_W  = 3;
   localparam int BANK_AW = 5;
   localparam int BANK_SZ = 32;

   logic                       clk_i = 1'b0;
   logic                       rst_i;
   logic                       valid_i;
   logic [NUM_BU*AW-1:0]       addr_i;
   logic [AW-1:0]              olen_i;
   logic                       done_i;
   logic [NUM_BU*BANK_AW-1:0]  addr_a_o;
   logic [NUM_BU*BANK_AW-1:0]  addr_b_o;
   logic [NUM_BU-1:0]          en_a_o;
   logic [NUM_BU-1:0]          en_b_o;
   logic                       valid_o;
   logic [NUM_BU*LANE_W-1:0]   sel_a_o;
   logic [NUM_BU*LANE_W-1:0]   sel_b_o;
   logic                       sel_valid_o;
   logic                       done_o;
   logic                       conflict_o;
   logic [15:0]                conflict_cnt_o;

   bram_bank_router #(
      .NUM_BU     (NUM_BU),
      .ADDR_WIDTH (AW),
      .RD_LAT     (RD_LAT)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .valid_i        (valid_i),
      .addr_i         (addr_i),
      .olen_i         (olen_i),
      .done_i         (done_i),
      .addr_a_o       (addr_a_o),
      .addr_b_o       (addr_b_o),
      .en_a_o         (en_a_o),
      .en_b_o         (en_b_o),
      .valid_o        (valid_o),
      .sel_a_o        (sel_a_o),
      .sel_b_o        (sel_b_o),
      .sel_valid_o    (sel_valid_o),
      .done_o         (done_o),
      .conflict_o     (conflict_o),
      .conflict_cnt_o (conflict_cnt_o)
   );

   // ---------------- clock ----------------
   always #5 clk_i = ~clk_i;

   // ---------------- model types ----------------
   typedef struct packed {
      logic                 valid;
      logic                 done;
      logic [NUM_BU*AW-1:0] addr;
      logic [AW-1:0]        olen;
   } in_t;

   typedef struct packed {
      logic                      valid;
      logic                      done;
      logic [NUM_BU-1:0]         en_a;
      logic [NUM_BU-1:0]         en_b;
      logic [NUM_BU*BANK_AW-1:0] addr_a;
      logic [NUM_BU*BANK_AW-1:0] addr_b;
      logic [NUM_BU*LANE_W-1:0]  sel_a;
      logic [NUM_BU*LANE_W-1:0]  sel_b;
      logic                      conflict;
   } exp_t;

   int n_checks = 0;
   int n_fail   = 0;

   in_t  p1_in  = '0;
   in_t  p2_in  = '0;
   logic p1_rst = 1'b1;
   logic p2_rst = 1'b1;
   int   m_cnt  = 0;

   logic win_en  = 1'b0;
   int   win_vcnt = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model(input in_t x);
      exp_t e;
      int   hits_a;
      int   hits_b;
      int   a;
      int   b;
      e       = '0;
      e.valid = x.valid;
      e.done  = x.done;
      if (x.valid) begin
         for (int bank = 0; bank < NUM_BU; bank++) begin
            hits_a = 0;
            hits_b = 0;
            for (int k = 0; k < NUM_BU; k++) begin
               a = int'(x.addr[k*AW +: AW]);
               b = (a + int'(x.olen)) % 256;
               if (a / BANK_SZ == bank) begin
                  if (hits_a == 0) begin
                     e.en_a[bank]                    = 1'b1;
                     e.addr_a[bank*BANK_AW +: BANK_AW] = BANK_AW'(a % BANK_SZ);
                     e.sel_a[bank*LANE_W +: LANE_W]    = LANE_W'(k);
                  end
                  hits_a++;
               end
               if (b / BANK_SZ == bank) begin
                  if (hits_b == 0) begin
                     e.en_b[bank]                    = 1'b1;
                     e.addr_b[bank*BANK_AW +: BANK_AW] = BANK_AW'(b % BANK_SZ);
                     e.sel_b[bank*LANE_W +: LANE_W]    = LANE_W'(k);
                  end
                  hits_b++;
               end
            end
`ifdef BRAM_ROUTE_CONFLICT_CHK_EN
            if (hits_a > 1 || hits_b > 1) e.conflict = 1'b1;
`endif
         end
      end
      return e;
   endfunction

   // One clock: sample the driven inputs at the edge, build expectations,
   // then compare every output 1 ns after the edge.
   task automatic tick();
      in_t  cur;
      logic cur_rst;
      exp_t e_out;
      exp_t e_sel;
      @(posedge clk_i);
      cur     = {valid_i, done_i, addr_i, olen_i};
      cur_rst = rst_i;
      e_out   = (cur_rst || p1_rst) ? '0 : model(p1_in);
      e_sel   = (cur_rst || p1_rst || p2_rst) ? '0 : model(p2_in);
      if (cur_rst) m_cnt = 0;
      else if (e_out.conflict && m_cnt < 65535) m_cnt++;
      p2_in  = p1_in;
      p2_rst = p1_rst;
      p1_in  = cur;
      p1_rst = cur_rst;
      #1;
      check("valid_o",     64'(valid_o),        64'(e_out.valid));
      check("done_o",      64'(done_o),         64'(e_out.done));
      check("en_a_o",      64'(en_a_o),         64'(e_out.en_a));
      check("en_b_o",      64'(en_b_o),         64'(e_out.en_b));
      check("addr_a_o",    64'(addr_a_o),       64'(e_out.addr_a));
      check("addr_b_o",    64'(addr_b_o),       64'(e_out.addr_b));
      check("conflict_o",  64'(conflict_o),     64'(e_out.conflict));
      check("conflict_cnt",64'(conflict_cnt_o), 64'(m_cnt));
      check("sel_valid_o", 64'(sel_valid_o),    64'(e_sel.valid));
      check("sel_a_o",     64'(sel_a_o),        64'(e_sel.sel_a));
      check("sel_b_o",     64'(sel_b_o),        64'(e_sel.sel_b));
      if (win_en && valid_o) win_vcnt++;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic v, input logic [NUM_BU*AW-1:0] a,
                        input logic [AW-1:0] ol, input logic d);
      valid_i = v;
      addr_i  = a;
      olen_i  = ol;
      done_i  = d;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0);
   endtask

   // Lane k gets base + k*step (mod 256).
   function automatic logic [NUM_BU*AW-1:0] lanes(input int base, input int step);
      logic [NUM_BU*AW-1:0] v;
      v = '0;
      for (int k = 0; k < NUM_BU; k++) v[k*AW +: AW] = AW'((base + k*step) % 256);
      return v;
   endfunction

   function automatic logic [NUM_BU*AW-1:0] rand_perm_lanes();
      logic [NUM_BU*AW-1:0] v;
      int perm [NUM_BU];
      int j;
      int t;
      for (int k = 0; k < NUM_BU; k++) perm[k] = k;
      for (int k = NUM_BU-1; k > 0; k--) begin
         j = $urandom_range(0, k);
         t = perm[k]; perm[k] = perm[j]; perm[j] = t;
      end
      for (int k = 0; k < NUM_BU; k++)
         v[k*AW +: AW] = AW'(perm[k]*BANK_SZ + $urandom_range(0, BANK_SZ-1));
      return v;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      logic [NUM_BU*AW-1:0] a;

      rst_i   = 1'b1;
      valid_i = 1'b0;
      addr_i  = '0;
      olen_i  = '0;
      done_i  = 1'b0;
      tick();
      tick();
      tick();
      rst_i = 1'b0;
      idle(3);

      // No-conflict beat: every bank A offset 0, B offset 16, sel = bank.
      drive(1'b1, lanes(0, 32), 8'd16, 1'b0);
      idle(4);

      // Wrap-around: lane 7 at 0xF8 partners 0x08 in bank 0.
      a = lanes(8'h14, 32);
      a[7*AW +: AW] = 8'hF8;
      drive(1'b1, a, 8'h10, 1'b0);
      idle(4);

      // Conflict: lanes 0 and 3 both at 0x05.
      a = lanes(0, 32);
      a[0*AW +: AW] = 8'h05;
      a[3*AW +: AW] = 8'h05;
      drive(1'b1, a, 8'd16, 1'b0);
      idle(4);

      // Colliding addresses without valid produce nothing.
      drive(1'b0, '0, 8'd3, 1'b0);
      idle(4);

      // Streaming: 64 back-to-back beats then a done pulse.
      win_en   = 1'b1;
      win_vcnt = 0;
      for (int i = 0; i < 64; i++) drive(1'b1, rand_perm_lanes(), AW'($urandom_range(0, 255)), 1'b0);
      drive(1'b0, '0, '0, 1'b1);
      idle(5);
      win_en = 1'b0;
      check("stream_valid_count", 64'(win_vcnt), 64'd64);

      // Reset during beat 10 of a stream.
      for (int i = 0; i < 20; i++) begin
         rst_i = (i == 10);
         drive(1'b1, {$urandom, $urandom}, AW'($urandom_range(0, 255)), (i == 9));
      end
      rst_i = 1'b0;
      idle(5);

      // Random traffic with occasional done and reset.
      for (int i = 0; i < 400; i++) begin
         rst_i = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 1) == 0) a = rand_perm_lanes();
         else a = {$urandom, $urandom};
         drive($urandom_range(0, 3) != 0, a, AW'($urandom_range(0, 255)),
               $urandom_range(0, 15) == 0);
      end
      rst_i = 1'b0;
      idle(5);

`ifdef BRAM_ROUTE_CONFLICT_CHK_EN
      // Saturation: every beat collides on bank 0.
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      for (int i = 0; i < 65540; i++) drive(1'b1, '0, 8'd1, 1'b0);
      idle(3);
      check("cnt_saturated", 64'(conflict_cnt_o), 64'hFFFF);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
